// File: rtl/hook_controller.sv
// hook_controller: sequences the fishing-line/hook overlay. Generates the hook
// position (tenth-pixel units) consumed by the pixel colour mux, driven by a
// cast -> drop -> wait -> reel -> catch state machine that advances on the
// per-frame tick.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   tick         one-cycle frame strobe; motion updates only on tick cycles
//   cast         one-cycle cast request
//   reel         one-cycle early-reel request
//   fish_hit     one-cycle hook/fish collision pulse
//   h_position   hook horizontal position, tenth-pixels (14 bit)
//   v_position   hook vertical position, tenth-pixels (14 bit)
//   state        IDLE=0, DROP=1, WAIT=2, REEL=3, CATCH=4
//   caught       a fish is attached to the current cast
//   catch_pulse  one-cycle pulse the cycle after the tick that enters CATCH
//   busy         high in every state except IDLE
module hook_controller #(
    parameter int unsigned H_HOME      = 2580,
    parameter int unsigned SWAY        = 30,
    parameter int unsigned V_TOP       = 720,
    parameter int unsigned V_BOTTOM    = 4600,
    parameter int unsigned DROP_STEP   = 20,
    parameter int unsigned REEL_STEP   = 30,
    parameter int unsigned WAIT_TICKS  = 180,
    parameter int unsigned CATCH_TICKS = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        cast,
    input  logic        reel,
    input  logic        fish_hit,
    output logic [13:0] h_position,
    output logic [13:0] v_position,
    output logic [2:0]  state,
    output logic        caught,
    output logic        catch_pulse,
    output logic        busy
);

    localparam int unsigned POS_W   = 14;
    localparam int unsigned CNT_MAX = (WAIT_TICKS > CATCH_TICKS) ? WAIT_TICKS : CATCH_TICKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [POS_W-1:0] H_HOME_P  = POS_W'(H_HOME);
    localparam logic [POS_W-1:0] H_MIN_P   = POS_W'(H_HOME - SWAY);
    localparam logic [POS_W-1:0] H_MAX_P   = POS_W'(H_HOME + SWAY);
    localparam logic [POS_W-1:0] V_TOP_P   = POS_W'(V_TOP);
    localparam logic [POS_W-1:0] V_BOT_P   = POS_W'(V_BOTTOM);
    localparam logic [POS_W-1:0] D_STEP_P  = POS_W'(DROP_STEP);
    localparam logic [POS_W-1:0] R_STEP_P  = POS_W'(REEL_STEP);
    // Saturation thresholds: compared before stepping so the arithmetic never wraps.
    localparam logic [POS_W-1:0] DROP_LIM  = POS_W'(V_BOTTOM - DROP_STEP);
    localparam logic [POS_W-1:0] REEL_LIM  = POS_W'(V_TOP + REEL_STEP);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_TICKS);
    localparam logic [CNT_W-1:0] CATCH_LAST = CNT_W'(CATCH_TICKS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DROP  = 3'd1,
        S_WAIT  = 3'd2,
        S_REEL  = 3'd3,
        S_CATCH = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [POS_W-1:0]   h_q, h_d;
    logic [POS_W-1:0]   v_q, v_d;
    logic               dir_q, dir_d;      // sway direction: 0 = toward +, 1 = toward -
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               caught_q, caught_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               cast_f_q, cast_f_d;
    logic               reel_f_q, reel_f_d;
    logic               hit_f_q, hit_f_d;

    logic               cast_req, reel_req, hit_req;
    logic [POS_W-1:0]   h_sway;
    logic               dir_sway;
    logic [CNT_W-1:0]   cnt_inc;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            h_q      <= H_HOME_P;
            v_q      <= V_TOP_P;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
            caught_q <= 1'b0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            cast_f_q <= 1'b0;
            reel_f_q <= 1'b0;
            hit_f_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            caught_q <= caught_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            cast_f_q <= cast_f_d;
            reel_f_q <= reel_f_d;
            hit_f_q  <= hit_f_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        caught_d = caught_q;
        pulse_d  = 1'b0;
        cast_f_d = cast_f_q | cast;
        reel_f_d = reel_f_q | reel;
        hit_f_d  = hit_f_q | fish_hit;

        // A pulse arriving on the tick itself is seen by that tick.
        cast_req = cast_f_q | cast;
        reel_req = reel_f_q | reel;
        hit_req  = hit_f_q | fish_hit;
        cnt_inc  = cnt_q + CNT_W'(1);

        // Sway bounces off the limits: reverse and step back in the same tick.
        if (!dir_q) begin
            if (h_q >= H_MAX_P) begin
                h_sway   = h_q - POS_W'(1);
                dir_sway = 1'b1;
            end else begin
                h_sway   = h_q + POS_W'(1);
                dir_sway = 1'b0;
            end
        end else begin
            if (h_q <= H_MIN_P) begin
                h_sway   = h_q + POS_W'(1);
                dir_sway = 1'b0;
            end else begin
                h_sway   = h_q - POS_W'(1);
                dir_sway = 1'b1;
            end
        end

        if (tick) begin
            // Every latched request is consumed (or discarded) by this tick.
            cast_f_d = 1'b0;
            reel_f_d = 1'b0;
            hit_f_d  = 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    v_d = V_TOP_P;
                    h_d = H_HOME_P;
                    if (cast_req) begin
                        state_d  = S_DROP;
                        caught_d = 1'b0;
                        dir_d    = 1'b0;
                    end
                end
                S_DROP: begin
                    h_d   = h_sway;
                    dir_d = dir_sway;
                    if (hit_req) begin
                        caught_d = 1'b1;
                        state_d  = S_REEL;
                    end else if (reel_req) begin
                        state_d = S_REEL;
                    end else if (v_q >= DROP_LIM) begin
                        v_d     = V_BOT_P;
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        v_d = v_q + D_STEP_P;
                    end
                end
                S_WAIT: begin
                    h_d   = h_sway;
                    dir_d = dir_sway;
                    if (hit_req) begin
                        caught_d = 1'b1;
                        state_d  = S_REEL;
                    end else if (reel_req) begin
                        state_d = S_REEL;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == WAIT_LAST) begin
                            state_d = S_REEL;
                        end
                    end
                end
                S_REEL: begin
                    if (v_q <= REEL_LIM) begin
                        v_d     = V_TOP_P;
                        h_d     = H_HOME_P;
                        cnt_d   = '0;
                        state_d = caught_q ? S_CATCH : S_IDLE;
                        pulse_d = caught_q;
                    end else begin
                        v_d   = v_q - R_STEP_P;
                        h_d   = h_sway;
                        dir_d = dir_sway;
                    end
                end
                S_CATCH: begin
                    v_d   = V_TOP_P;
                    h_d   = H_HOME_P;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CATCH_LAST) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    v_d     = V_TOP_P;
                    h_d     = H_HOME_P;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign state       = state_q;
    assign h_position  = h_q;
    assign v_position  = v_q;
    assign caught      = caught_q;
    assign catch_pulse = pulse_q;
    assign busy        = busy_q;

endmodule
